// File: rtl/qdiv_issue.sv
// qdiv_issue: operand-side front end for the sequential Q-format divider.
// Buffers dividend/divisor pairs in a small FIFO, launches one division at a
// time over the divider start/complete handshake, and holds each quotient for
// a valid/ready consumer together with a divide-by-zero flag.
//
// Optional feature macro: QDIV_DZ_BYPASS_EN
//   defined   - zero-magnitude divisors are answered locally with a saturated
//               quotient and out_dz=1, and never reach the divider
//   undefined - every entry goes to the divider and out_dz stays 0
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           upstream operand handshake
//   in_dividend/in_divisor      sign-magnitude operands
//   out_valid/out_ready         downstream result handshake
//   out_quotient/out_dz         result and zero-divisor flag
//   div_start                   one-cycle start pulse to the divider
//   div_dividend/div_divisor    operands held for the divider
//   div_complete/div_quotient   divider status and result
//   fifo_level                  entries currently buffered
//   busy                        FSM not idle
module qdiv_issue #(
  parameter int unsigned N     = 32,
  parameter int unsigned Q     = 15,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_dividend,
  input  logic [N-1:0]  in_divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_quotient,
  output logic          out_dz,
  output logic          div_start,
  output logic [N-1:0]  div_dividend,
  output logic [N-1:0]  div_divisor,
  input  logic          div_complete,
  input  logic [N-1:0]  div_quotient,
  output logic [AW:0]   fifo_level,
  output logic          busy
);

  // Reject configurations the divider or the pointer arithmetic cannot honour.
  if (Q >= N || DEPTH != (1 << AW) || DEPTH < 2) begin : g_cfg_err
    $error("qdiv_issue: illegal parameter combination");
  end

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_HOLD
  } state_t;

  state_t          state_q;
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     level_q, level_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [N-1:0]    out_quotient_q;
  logic            out_dz_q;
  logic            div_start_q;
  logic [N-1:0]    div_dividend_q, div_divisor_q;
  entry_t          head;
  logic            push, pop;

  assign head = mem_q[rptr_q];
  assign push = in_valid && in_ready_q;
  // Pop only when idle, the divider is free and no result is waiting.
  assign pop  = (state_q == ST_IDLE) && (level_q != '0) && div_complete && !out_valid_q;

  // Next FIFO occupancy.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Operand storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{dividend: in_dividend, divisor: in_divisor};
  end

  // FIFO pointers, level and registered ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q    <= level_d;
      in_ready_q <= (level_d != FULL_LVL);
    end
  end

  // Job sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      out_valid_q    <= 1'b0;
      out_quotient_q <= '0;
      out_dz_q       <= 1'b0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
`ifdef QDIV_DZ_BYPASS_EN
            // Zero magnitude divisor: answer locally with saturated magnitude.
            if (head.divisor[N-2:0] == '0) begin
              out_quotient_q <= {head.dividend[N-1] ^ head.divisor[N-1], {(N-1){1'b1}}};
              out_dz_q       <= 1'b1;
              out_valid_q    <= 1'b1;
              state_q        <= ST_HOLD;
            end else
`endif
            begin
              div_dividend_q <= head.dividend;
              div_divisor_q  <= head.divisor;
              div_start_q    <= 1'b1;
              state_q        <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: state_q <= ST_WAIT_LO;
        // Divider must first acknowledge the start by dropping complete.
        ST_WAIT_LO: if (!div_complete) state_q <= ST_WAIT_HI;
        ST_WAIT_HI: begin
          if (div_complete) begin
            out_quotient_q <= div_quotient;
            out_dz_q       <= 1'b0;
            out_valid_q    <= 1'b1;
            state_q        <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_quotient = out_quotient_q;
  assign out_dz       = out_dz_q;
  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign fifo_level   = level_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qdiv_issue.sv
// Directed bench for qdiv_issue with a behavioural sequential divider model.
module tb_qdiv_issue;

  localparam int unsigned N = 32;
  localparam int unsigned Q = 15;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW = 2;
  localparam int RUN = N + Q - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_dividend = '0;
  logic [N-1:0]  in_divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_quotient;
  logic          out_dz;
  logic          div_start;
  logic [N-1:0]  div_dividend;
  logic [N-1:0]  div_divisor;
  logic          div_complete;
  logic [N-1:0]  div_quotient;
  logic [AW:0]   fifo_level;
  logic          busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qdiv_issue #(.N(N), .Q(Q), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_dz(out_dz),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_complete(div_complete), .div_quotient(div_quotient),
    .fifo_level(fifo_level), .busy(busy)
  );

  // Sign-magnitude Q-format quotient; zero divisor saturates the magnitude.
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num;
    logic [63:0] quo;
    if (b[30:0] == 31'd0) begin
      quo = 64'h7FFF_FFFF;
    end else begin
      num = {33'd0, a[30:0]} << Q;
      quo = num / {33'd0, b[30:0]};
    end
    return {a[31] ^ b[31], quo[30:0]};
  endfunction

  // Divider model: complete drops after start, rises RUN cycles later. Not reset.
  logic        m_complete = 1'b1;
  logic [31:0] m_quot = '0;
  logic [31:0] m_res = '0;
  int          m_cnt = 0;
  assign div_complete = m_complete;
  assign div_quotient = m_quot;

  always @(posedge clk) begin
    if (div_start) begin
      m_cnt      <= RUN;
      m_complete <= 1'b0;
      m_res      <= model_div(div_dividend, div_divisor);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_complete <= 1'b1;
        m_quot     <= m_res;
      end
    end
  end

  // Start pulse counters.
  int   start_cnt = 0;
  int   dbl_cnt = 0;
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    if (div_start) start_cnt <= start_cnt + 1;
    if (div_start && prev_start) dbl_cnt <= dbl_cnt + 1;
    prev_start <= div_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_dividend = a;
    in_divisor = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int s0;
  int n;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_quot", out_quotient, 32'h0);
    chk("rst_dz", 32'(out_dz), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_dividend", div_dividend, 32'h0);
    chk("rst_div_divisor", div_divisor, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 3.0 / 2.0
    s0 = start_cnt;
    push(32'h0001_8000, 32'h0001_0000);
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_div_dividend", div_dividend, 32'h0001_8000);
    chk("t1_div_divisor", div_divisor, 32'h0001_0000);
    wait_valid("t1_valid");
    chk("t1_quot", out_quotient, 32'h0000_C000);
    chk("t1_dz", 32'(out_dz), 32'd0);
    chk("t1_start_once", 32'(start_cnt - s0), 32'd1);
    chk("t1_start_width", 32'(dbl_cnt), 32'd0);
    accept();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);

    // 2: -3.0 / 2.0
    push(32'h8001_8000, 32'h0001_0000);
    wait_valid("t2_valid");
    chk("t2_quot", out_quotient, 32'h8000_C000);
    accept();

    // 3: divide by zero
    s0 = start_cnt;
    push(32'h8000_8000, 32'h0000_0000);
`ifdef QDIV_DZ_BYPASS_EN
    @(negedge clk);
    chk("t3_bypass_latency", 32'(out_valid), 32'd1);
`endif
    wait_valid("t3_valid");
    chk("t3_quot", out_quotient, 32'hFFFF_FFFF);
`ifdef QDIV_DZ_BYPASS_EN
    chk("t3_dz", 32'(out_dz), 32'd1);
    chk("t3_no_start", 32'(start_cnt - s0), 32'd0);
`else
    chk("t3_dz", 32'(out_dz), 32'd0);
    chk("t3_start", 32'(start_cnt - s0), 32'd1);
`endif
    accept();

    // 4: back-pressure with five 1.0 / 1.0 jobs
    for (int i = 0; i < 5; i++) push(32'h0000_8000, 32'h0000_8000);
    chk("t4_level_full", 32'(fifo_level), 32'd4);
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    wait_valid("t4_first_valid");
    chk("t4_first_quot", out_quotient, 32'h0000_8000);
    repeat (5) @(negedge clk);
    chk("t4_hold_valid", 32'(out_valid), 32'd1);
    chk("t4_hold_quot", out_quotient, 32'h0000_8000);
    chk("t4_hold_level", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 5; i++) begin
      wait_valid("t4_valid");
      chk("t4_quot", out_quotient, 32'h0000_8000);
      accept();
    end
    chk("t4_level_empty", 32'(fifo_level), 32'd0);
    chk("t4_in_ready_high", 32'(in_ready), 32'd1);

    // 5: reset during WAIT_HI
    s0 = start_cnt;
    push(32'h0000_8000, 32'h0000_8000);
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_level", 32'(fifo_level), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    s0 = start_cnt;
    push(32'h0000_8000, 32'h0000_8000);
    wait_valid("t5_valid");
    chk("t5_quot", out_quotient, 32'h0000_8000);
    chk("t5_dz", 32'(out_dz), 32'd0);
    chk("t5_start_once", 32'(start_cnt - s0), 32'd1);
    accept();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
